if_stage_fetch: RTL and testbench

- Instruction-fetch stage of the ARM pipeline. It is the front of the chain that ends at the WB stage.
- Owns the program counter and drives the instruction-memory request/response handshake.
- Absorbs ID-stage freezes in a one-entry skid buffer and applies branch redirects from EXE.
- Produces the registered IF/ID payload (pc, instruction, valid) consumed by the ID stage.

---
 rtl/if_stage_fetch.sv | 133 +++++++++++++
 tb/tb_if_stage_fetch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// if_stage_fetch
// Instruction-fetch stage: owns the program counter, runs the instruction
// memory request/response handshake, parks one returned instruction in a
// skid buffer while ID is frozen, and applies branch redirects from EXE.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   freeze               ID hazard stall; IF/ID must hold
//   branch_taken         one-cycle redirect pulse from EXE
//   branch_addr          redirect target
//   imem_req, imem_addr  fetch request / address (combinational)
//   imem_ready           imem_rdata is valid for imem_addr this cycle
//   imem_rdata           fetched instruction word
//   if_id_pc             fetched address + 4 (registered)
//   if_id_instruction    fetched instruction (registered)
//   if_id_valid          IF/ID holds a real instruction (registered)
module if_stage_fetch #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   branch_taken,
   input  logic [ADDR_WIDTH-1:0]  branch_addr,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_ready,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [ADDR_WIDTH-1:0]  if_id_pc,
   output logic [INSTR_WIDTH-1:0] if_id_instruction,
   output logic                   if_id_valid
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]  pc_plus4;

   logic [ADDR_WIDTH-1:0]  skid_pc_p0, skid_pc_d;
   logic [INSTR_WIDTH-1:0] skid_instr_p0, skid_instr_d;
   logic                   skid_vld_p0, skid_vld_d;

   logic [ADDR_WIDTH-1:0]  ifid_pc_d;
   logic [INSTR_WIDTH-1:0] ifid_instr_d;
   logic                   ifid_vld_d;

   // Modulo 2^ADDR_WIDTH; low bits pass through, no alignment enforced.
   assign pc_plus4  = pc_q + ADDR_WIDTH'(4);
   assign imem_addr = pc_q;
   // Request is suppressed in the reset cycle and while parked in HOLD.
   assign imem_req  = (state_q == FETCH) && !rst;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      skid_pc_d    = skid_pc_p0;
      skid_instr_d = skid_instr_p0;
      skid_vld_d   = skid_vld_p0;
      ifid_pc_d    = if_id_pc;
      ifid_instr_d = if_id_instruction;
      ifid_vld_d   = if_id_valid;

      if (branch_taken) begin
         // Redirect wins over freeze and discards any same-cycle response.
         pc_d         = branch_addr;
         state_d      = FETCH;
         skid_vld_d   = 1'b0;
         ifid_pc_d    = '0;
         ifid_instr_d = '0;
         ifid_vld_d   = 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  pc_d = pc_plus4;
                  if (!freeze) begin
                     ifid_pc_d    = pc_plus4;
                     ifid_instr_d = imem_rdata;
                     ifid_vld_d   = 1'b1;
                  end else begin
                     // ID cannot take it: park the word so the access is not lost.
                     skid_pc_d    = pc_plus4;
                     skid_instr_d = imem_rdata;
                     skid_vld_d   = 1'b1;
                     state_d      = HOLD;
                  end
               end else if (!freeze) begin
                  ifid_pc_d    = '0;
                  ifid_instr_d = '0;
                  ifid_vld_d   = 1'b0;
               end
            end
            HOLD: begin
               if (!freeze) begin
                  ifid_pc_d    = skid_pc_p0;
                  ifid_instr_d = skid_instr_p0;
                  ifid_vld_d   = 1'b1;
                  skid_vld_d   = 1'b0;
                  state_d      = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // Stage boundary: PC, skid buffer and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= FETCH;
         pc_q              <= RESET_PC;
         skid_pc_p0        <= '0;
         skid_instr_p0     <= '0;
         skid_vld_p0       <= 1'b0;
         if_id_pc          <= '0;
         if_id_instruction <= '0;
         if_id_valid       <= 1'b0;
      end else begin
         state_q           <= state_d;
         pc_q              <= pc_d;
         skid_pc_p0        <= skid_pc_d;
         skid_instr_p0     <= skid_instr_d;
         skid_vld_p0       <= skid_vld_d;
         if_id_pc          <= ifid_pc_d;
         if_id_instruction <= ifid_instr_d;
         if_id_valid       <= ifid_vld_d;
      end
   end

endmodule

// File: tb/tb_if_stage_fetch.sv
module tb_if_stage_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
   logic        if_id_valid;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        vld;
   } ifid_t;

   ifid_t sb[$];

   if_stage_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .branch_taken(branch_taken), .branch_addr(branch_addr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .if_id_pc(if_id_pc), .if_id_instruction(if_id_instruction),
      .if_id_valid(if_id_valid)
   );

   always #5 clk = ~clk;

   // Memory content is tagged by address so every word is distinguishable.
   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hE5A0_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational request side, queue the
   // expected IF/ID contents, then compare them after the edge.
   task automatic step(input string name,
                       input logic r, input logic rdy, input logic frz,
                       input logic br, input logic [31:0] ba,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic [31:0] epc, input logic [31:0] einstr,
                       input logic ev);
      ifid_t e;
      rst          = r;
      imem_ready   = rdy;
      freeze       = frz;
      branch_taken = br;
      branch_addr  = ba;
      imem_rdata   = word(eaddr);
      #1;
      chk({name, ".req"}, {31'b0, imem_req}, {31'b0, ereq});
      chk({name, ".addr"}, imem_addr, eaddr);
      sb.push_back('{pc: epc, instr: einstr, vld: ev});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", name);
      end else begin
         e = sb.pop_front();
         chk({name, ".pc"}, if_id_pc, e.pc);
         chk({name, ".instr"}, if_id_instruction, e.instr);
         chk({name, ".vld"}, {31'b0, if_id_valid}, {31'b0, e.vld});
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      imem_ready = 1'b1; imem_rdata = '0;
      @(posedge clk); #1;

      // Reset with memory claiming ready: response ignored, IF/ID cleared.
      step("rst0", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
      step("rst1", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

      // Streaming with single-cycle memory.
      step("str0", 0, 1, 0, 0, 0, 1, 32'h0,  32'h4,  word(32'h0),  1);
      step("str1", 0, 1, 0, 0, 0, 1, 32'h4,  32'h8,  word(32'h4),  1);
      step("str2", 0, 1, 0, 0, 0, 1, 32'h8,  32'hC,  word(32'h8),  1);
      step("str3", 0, 1, 0, 0, 0, 1, 32'hC,  32'h10, word(32'hC),  1);

      // Two-cycle memory: address held, bubbles interleaved, nothing skipped.
      step("ws0", 0, 0, 0, 0, 0, 1, 32'h10, 32'h0,  32'h0,         0);
      step("ws1", 0, 1, 0, 0, 0, 1, 32'h10, 32'h14, word(32'h10),  1);
      step("ws2", 0, 0, 0, 0, 0, 1, 32'h14, 32'h0,  32'h0,         0);
      step("ws3", 0, 1, 0, 0, 0, 1, 32'h14, 32'h18, word(32'h14),  1);

      // Freeze as the word at 0x1C returns: IF/ID keeps the 0x18 word.
      step("fz0", 0, 1, 0, 0, 0, 1, 32'h18, 32'h1C, word(32'h18),  1);
      step("fz1", 0, 1, 1, 0, 0, 1, 32'h1C, 32'h1C, word(32'h18),  1);
      step("fz2", 0, 1, 1, 0, 0, 0, 32'h20, 32'h1C, word(32'h18),  1);
      step("fz3", 0, 1, 1, 0, 0, 0, 32'h20, 32'h1C, word(32'h18),  1);
      step("fz4", 0, 0, 0, 0, 0, 0, 32'h20, 32'h20, word(32'h1C),  1);
      step("fz5", 0, 1, 0, 0, 0, 1, 32'h20, 32'h24, word(32'h20),  1);

      // Branch with simultaneous ready and freeze: word dropped, flush.
      step("br0", 0, 1, 1, 1, 32'h100, 1, 32'h24,  32'h0,   32'h0,         0);
      step("br1", 0, 1, 0, 0, 0,       1, 32'h100, 32'h104, word(32'h100), 1);

      // Branch to the top of the address space; pc+4 wraps to 0.
      step("wr0", 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h104,       32'h0, 32'h0,               0);
      step("wr1", 0, 1, 0, 0, 0,             1, 32'hFFFF_FFFC, 32'h0, word(32'hFFFF_FFFC), 1);
      step("wr2", 0, 0, 0, 0, 0,             1, 32'h0,         32'h0, 32'h0,               0);

      // Park a word in HOLD, then reset: skid discarded, restart at 0.
      step("hr0", 0, 1, 0, 0, 0, 1, 32'h0, 32'h4, word(32'h0), 1);
      step("hr1", 0, 1, 1, 0, 0, 1, 32'h4, 32'h4, word(32'h0), 1);
      step("hr2", 0, 1, 1, 0, 0, 0, 32'h8, 32'h4, word(32'h0), 1);
      step("hr3", 1, 1, 1, 0, 0, 0, 32'h8, 32'h0, 32'h0,       0);
      step("hr4", 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0,       0);
      step("hr5", 0, 1, 0, 0, 0, 1, 32'h0, 32'h4, word(32'h0), 1);

      // Unaligned target: low address bits carried through untouched.
      step("ua0", 0, 0, 0, 1, 32'h102, 1, 32'h4,   32'h0,   32'h0,         0);
      step("ua1", 0, 1, 0, 0, 0,       1, 32'h102, 32'h106, word(32'h102), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
